// File: rtl/whack_game_core.sv
// whack_game_core
//   Parametrised whack-a-mole game controller. Picks a target from the LFSR
//   index and keeps it up for a time window. The window shrinks with every
//   correct hit down to a floor. A wrong press locks that button for a
//   penalty period. The core counts score and misses until the game timer
//   runs out. All outputs are registered.
//
//   Optional build macro: STREAK_BONUS_EN
//     Adds a 3-bit saturating streak counter and a streak output port.
//     A correct hit made while the streak is 3 or more scores 2 points.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   start        debounced start level (rising edge starts a game)
//   hit          debounced button levels, one per target
//   rand_idx     random index from the LFSR
//   mole_onehot  active target, one-hot; zero when no mole is up
//   mole_idx     index of the current/last target
//   lockout      per-button penalty lock mask
//   score        correct hits (saturating)
//   misses       mole timeouts (saturating)
//   game_over    high in OVER
//   playing      high in SPAWN/UP
//   streak       consecutive correct hits (STREAK_BONUS_EN only)
module whack_game_core #(
  parameter int NUM_MOLES   = 8,
  parameter int SCORE_W     = 8,
  parameter int GAME_CYCLES = 15000000,
  parameter int LOCK_CYCLES = 1000000,
  parameter int WIN_INIT    = 2000000,
  parameter int WIN_MIN     = 400000,
  parameter int WIN_STEP    = 100000,
  localparam int IDX_W      = $clog2(NUM_MOLES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_MOLES-1:0] hit,
  input  logic [IDX_W-1:0]     rand_idx,
  output logic [NUM_MOLES-1:0] mole_onehot,
  output logic [IDX_W-1:0]     mole_idx,
  output logic [NUM_MOLES-1:0] lockout,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   misses,
  output logic                 game_over,
  output logic                 playing
`ifdef STREAK_BONUS_EN
  ,
  output logic [2:0]           streak
`endif
);

  localparam int GT_W = $clog2(GAME_CYCLES + 1);
  localparam int LK_W = $clog2(LOCK_CYCLES + 1);
  localparam int WN_W = $clog2(WIN_INIT + 1);
  localparam logic [IDX_W:0] NM = (IDX_W+1)'(NUM_MOLES);

  typedef enum logic [1:0] {S_IDLE, S_SPAWN, S_UP, S_OVER} state_t;

  state_t               state, state_d;
  logic [NUM_MOLES-1:0] hit_q;
  logic                 start_q;
  logic [WN_W-1:0]      window, window_d;
  logic [GT_W-1:0]      game_tmr, game_tmr_d;
  logic [LK_W-1:0]      lock_tmr, lock_tmr_d;
  logic [WN_W-1:0]      mole_tmr, mole_tmr_d;
  logic [SCORE_W-1:0]   score_d, misses_d;
  logic [NUM_MOLES-1:0] lockout_d;
  logic [IDX_W-1:0]     mole_idx_d;
  logic [1:0]           bonus;
`ifdef STREAK_BONUS_EN
  logic [2:0]           streak_d;
`endif

  logic [NUM_MOLES-1:0] rise, wrong, target;
  logic                 correct, start_rise;
  logic [IDX_W:0]       idx_norm, idx_pick;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [1:0]         inc);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + (SCORE_W+1)'(inc);
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

  // Next window after a correct hit: step down, never below the floor.
  function automatic logic [WN_W-1:0] shrink(input logic [WN_W-1:0] w);
    logic [WN_W:0] wide;
    wide = {1'b0, w};
    if (wide >= (WN_W+1)'(WIN_MIN + WIN_STEP)) return w - WN_W'(WIN_STEP);
    else return WN_W'(WIN_MIN);
  endfunction

  function automatic logic [NUM_MOLES-1:0] onehot(input logic [IDX_W-1:0] i);
    return {{(NUM_MOLES-1){1'b0}}, 1'b1} << i;
  endfunction

  // Locked buttons never produce a rise; hit_q tracks them regardless, so a
  // button held through the end of its lock does not fire on release of lock.
  assign rise       = hit & ~hit_q & ~lockout;
  assign start_rise = start & ~start_q;
  assign target     = onehot(mole_idx);
  assign correct    = |(rise & target);
  assign wrong      = rise & ~target;

  // Fold the LFSR index into range, then avoid repeating the last target.
  always_comb begin
    idx_norm = {1'b0, rand_idx};
    if (idx_norm >= NM) idx_norm = idx_norm - NM;
    idx_pick = idx_norm;
    if (idx_norm == {1'b0, mole_idx}) begin
      idx_pick = idx_norm + 1'b1;
      if (idx_pick == NM) idx_pick = '0;
    end
  end

  always_comb begin
    state_d    = state;
    score_d    = score;
    misses_d   = misses;
    lockout_d  = lockout;
    mole_idx_d = mole_idx;
    window_d   = window;
    game_tmr_d = game_tmr;
    lock_tmr_d = lock_tmr;
    mole_tmr_d = mole_tmr;
    bonus      = 2'd1;
`ifdef STREAK_BONUS_EN
    streak_d   = streak;
    if (streak >= 3'd3) bonus = 2'd2;
`endif

    // Lock timer runs in every state; OVER keeps all buttons locked.
    if (lock_tmr != '0) begin
      lock_tmr_d = lock_tmr - 1'b1;
      if (lock_tmr == LK_W'(1) && state != S_OVER) lockout_d = '0;
    end

    case (state)
      S_IDLE, S_OVER: begin
        if (start_rise) begin
          score_d    = '0;
          misses_d   = '0;
          lockout_d  = '0;
          lock_tmr_d = '0;
          game_tmr_d = GT_W'(GAME_CYCLES);
          window_d   = WN_W'(WIN_INIT);
`ifdef STREAK_BONUS_EN
          streak_d   = '0;
`endif
          state_d    = S_SPAWN;
        end
      end

      S_SPAWN: begin
        if (game_tmr != '0) game_tmr_d = game_tmr - 1'b1;
        mole_idx_d = idx_pick[IDX_W-1:0];
        mole_tmr_d = window;
        state_d    = S_UP;
      end

      S_UP: begin
        if (game_tmr != '0) game_tmr_d = game_tmr - 1'b1;
        if (mole_tmr != '0) mole_tmr_d = mole_tmr - 1'b1;
        // "Reaches zero" means this is the last counted cycle (value 1).
        if (game_tmr <= GT_W'(1)) begin
          state_d    = S_OVER;
          lockout_d  = '1;
          lock_tmr_d = '0;
        end else begin
          if (correct) begin
            score_d  = sat_add(score, bonus);
            window_d = shrink(window);
            state_d  = S_SPAWN;
`ifdef STREAK_BONUS_EN
            if (streak != 3'd7) streak_d = streak + 3'd1;
`endif
          end else if (mole_tmr <= WN_W'(1)) begin
            misses_d = sat_add(misses, 2'd1);
            state_d  = S_SPAWN;
`ifdef STREAK_BONUS_EN
            streak_d = '0;
`endif
          end
          // Wrong presses lock even when the target was also hit this cycle;
          // reloading the timer lets a fresh wrong press extend the lock.
          if (wrong != '0) begin
            lockout_d  = lockout | wrong;
            lock_tmr_d = LK_W'(LOCK_CYCLES);
`ifdef STREAK_BONUS_EN
            streak_d   = '0;
`endif
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      hit_q       <= '0;
      start_q     <= 1'b0;
      window      <= WN_W'(WIN_INIT);
      game_tmr    <= '0;
      lock_tmr    <= '0;
      mole_tmr    <= '0;
      score       <= '0;
      misses      <= '0;
      lockout     <= '0;
      mole_idx    <= '0;
      mole_onehot <= '0;
      game_over   <= 1'b0;
      playing     <= 1'b0;
`ifdef STREAK_BONUS_EN
      streak      <= '0;
`endif
    end else begin
      state       <= state_d;
      hit_q       <= hit;
      start_q     <= start;
      window      <= window_d;
      game_tmr    <= game_tmr_d;
      lock_tmr    <= lock_tmr_d;
      mole_tmr    <= mole_tmr_d;
      score       <= score_d;
      misses      <= misses_d;
      lockout     <= lockout_d;
      mole_idx    <= mole_idx_d;
      // Outputs follow the state being entered so they line up with it.
      mole_onehot <= (state_d == S_UP) ? onehot(mole_idx_d) : '0;
      game_over   <= (state_d == S_OVER);
      playing     <= (state_d == S_SPAWN) || (state_d == S_UP);
`ifdef STREAK_BONUS_EN
      streak      <= streak_d;
`endif
    end
  end

endmodule

// File: tb/tb_whack_game_core.sv
module tb_whack_game_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start2;
  logic [3:0] hit, hit2;
  logic [1:0] rand_idx, rand2;
  logic [3:0] mole_onehot, lockout, mole_onehot2, lockout2;
  logic [1:0] mole_idx, mole_idx2;
  logic [7:0] score, misses;
  logic [1:0] score2, misses2;
  logic       game_over, playing, game_over2, playing2;
`ifdef STREAK_BONUS_EN
  logic [2:0] streak, streak2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  whack_game_core #(
    .NUM_MOLES(4), .SCORE_W(8), .GAME_CYCLES(200), .LOCK_CYCLES(5),
    .WIN_INIT(20), .WIN_MIN(8), .WIN_STEP(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .hit(hit), .rand_idx(rand_idx),
    .mole_onehot(mole_onehot), .mole_idx(mole_idx), .lockout(lockout),
    .score(score), .misses(misses), .game_over(game_over), .playing(playing)
`ifdef STREAK_BONUS_EN
    , .streak(streak)
`endif
  );

  // Narrow-score instance for saturation.
  whack_game_core #(
    .NUM_MOLES(4), .SCORE_W(2), .GAME_CYCLES(1000), .LOCK_CYCLES(5),
    .WIN_INIT(20), .WIN_MIN(8), .WIN_STEP(4)
  ) u_sat (
    .clk(clk), .rst(rst), .start(start2), .hit(hit2), .rand_idx(rand2),
    .mole_onehot(mole_onehot2), .mole_idx(mole_idx2), .lockout(lockout2),
    .score(score2), .misses(misses2), .game_over(game_over2), .playing(playing2)
`ifdef STREAK_BONUS_EN
    , .streak(streak2)
`endif
  );

  typedef struct {
    logic [1:0] rnd;
    logic [1:0] idx;
    logic [3:0] onehot;
    logic [3:0] hmask;
    int         score;
    int         score_stk;
    int         stk;
    logic [3:0] lock;
  } vec_t;

  vec_t tbl[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int es(input int plain, input int stk);
`ifdef STREAK_BONUS_EN
    return stk;
`else
    return plain;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; hit = '0; start2 = 1'b0; hit2 = '0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic measure_up(output int n);
    n = 0;
    while (mole_onehot != '0 && n < 100) begin
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [1:0] sr[4];
    logic [1:0] si[4];
    int         ss[4];

    //               rnd   idx   onehot   hmask    sc sc_stk stk lock
    tbl[0] = '{2'd2, 2'd2, 4'b0100, 4'b0100, 1, 1, 1, 4'b0000};
    tbl[1] = '{2'd2, 2'd3, 4'b1000, 4'b1000, 2, 2, 2, 4'b0000};
    tbl[2] = '{2'd3, 2'd0, 4'b0001, 4'b0001, 3, 3, 3, 4'b0000};
    tbl[3] = '{2'd1, 2'd1, 4'b0010, 4'b0010, 4, 5, 4, 4'b0000};
    tbl[4] = '{2'd2, 2'd2, 4'b0100, 4'b0100, 5, 7, 5, 4'b0000};
    tbl[5] = '{2'd0, 2'd0, 4'b0001, 4'b0011, 6, 9, 0, 4'b0010};

    rand_idx = 2'd0; rand2 = 2'd0;
    do_reset();
    chk("rst_onehot", mole_onehot, 0);
    chk("rst_idx", mole_idx, 0);
    chk("rst_lockout", lockout, 0);
    chk("rst_score", score, 0);
    chk("rst_misses", misses, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_playing", playing, 0);

    // Start: one SPAWN cycle with the mole dark.
    start = 1'b1; step(); start = 1'b0;
    chk("start_playing", playing, 1);
    chk("start_spawn_dark", mole_onehot, 0);

    for (int i = 0; i < 6; i++) begin
      hit = '0; rand_idx = tbl[i].rnd; step();
      chk($sformatf("tbl%0d_onehot", i), mole_onehot, tbl[i].onehot);
      chk($sformatf("tbl%0d_idx", i), mole_idx, tbl[i].idx);
      hit = tbl[i].hmask; step();
      chk($sformatf("tbl%0d_score", i), score, es(tbl[i].score, tbl[i].score_stk));
      chk($sformatf("tbl%0d_lockout", i), lockout, tbl[i].lock);
      chk($sformatf("tbl%0d_spawn_dark", i), mole_onehot, 0);
`ifdef STREAK_BONUS_EN
      chk($sformatf("tbl%0d_streak", i), streak, tbl[i].stk);
`endif
    end

    // Lockout on button 1 lasts 5 cycles; presses during it are ignored.
    hit = '0; rand_idx = 2'd1; step();
    chk("lock_onehot", mole_onehot, 4'b0010);
    chk("lock_active0", lockout, 4'b0010);
    hit = 4'b0010; step();
    chk("lock_press_ignored", score, es(6, 9));
    chk("lock_still_up", mole_onehot, 4'b0010);
    step(); step();
    chk("lock_active4", lockout, 4'b0010);
    step();
    chk("lock_expired", lockout, 4'b0000);
    chk("lock_held_no_rise", score, es(6, 9));
    hit = '0; step();
    hit = 4'b0010; step();
    chk("lock_after_hit", score, es(7, 10));
    hit = '0; rand_idx = 2'd3; step();
    chk("floor_onehot", mole_onehot, 4'b1000);
    measure_up(n);
    chk("window_floor", n, 8);
    chk("floor_miss", misses, 1);

    // Reset mid-game restores the window; timeout and one shrink step.
    do_reset();
    chk("rst2_score", score, 0);
    rand_idx = 2'd2; start = 1'b1; step(); start = 1'b0; step();
    chk("m_onehot", mole_onehot, 4'b0100);
    measure_up(n);
    chk("window_init", n, 20);
    chk("m_misses1", misses, 1);
    rand_idx = 2'd1; step();
    chk("m_onehot2", mole_onehot, 4'b0010);
    hit = 4'b0010; step();
    chk("m_score", score, 1);
    hit = '0; rand_idx = 2'd0; step();
    measure_up(n);
    chk("window_16", n, 16);
    chk("m_misses2", misses, 2);

    // Game over after 200 SPAWN/UP cycles; mid-game start ignored.
    do_reset();
    rand_idx = 2'd0; start = 1'b1; step(); start = 1'b0;
    for (int i = 1; i <= 199; i++) begin
      start = (i == 50);
      step();
    end
    start = 1'b0;
    chk("g_not_over_yet", game_over, 0);
    chk("g_playing_last", playing, 1);
    step();
    chk("g_over", game_over, 1);
    chk("g_over_dark", mole_onehot, 0);
    chk("g_over_lock", lockout, 4'b1111);
    chk("g_over_misses", misses, 9);
    chk("g_over_playing", playing, 0);
    step(); step();
    chk("g_over_hold_lock", lockout, 4'b1111);
    start = 1'b1; step(); start = 1'b0;
    chk("g_restart_misses", misses, 0);
    chk("g_restart_score", score, 0);
    chk("g_restart_lock", lockout, 0);
    chk("g_restart_playing", playing, 1);
    chk("g_restart_over", game_over, 0);

    // Saturation with a 2-bit score.
    sr = '{2'd2, 2'd2, 2'd3, 2'd1};
    si = '{2'd2, 2'd3, 2'd0, 2'd1};
    ss = '{1, 2, 3, 3};
    start2 = 1'b1; step(); start2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hit2 = '0; rand2 = sr[i]; step();
      chk($sformatf("sat%0d_idx", i), mole_idx2, si[i]);
      hit2 = 4'b0001 << si[i]; step();
      chk($sformatf("sat%0d_score", i), score2, ss[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
